// File: rtl/multicycle_ctrl.sv
// Five-state multicycle control unit for the RV32 datapath (IF/ID/EX/MEM/WB).
// Optional MCTRL_ILLEGAL_TRAP_EN adds a sticky TRAP state and an 'illegal' output.
module multicycle_ctrl #(
    parameter int NUM_STATES = 5,
    parameter int ALU_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             Zero,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic [ALU_W-1:0] ALUCtrl,
    output logic             loadPC,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [2:0]       state_o
`ifdef MCTRL_ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);

    localparam int STATE_W = $clog2(NUM_STATES);

    typedef enum logic [STATE_W-1:0] {
        S_IF  = 0,
        S_ID  = 1,
        S_EX  = 2,
        S_MEM = 3,
        S_WB  = 4
`ifdef MCTRL_ILLEGAL_TRAP_EN
        ,
        S_TRAP = 5
`endif
    } state_t;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b1101;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       is_r, is_i, is_lw, is_sw, is_beq, illegal_op;
    logic [ALU_W-1:0] alu_dec;
    logic       unused_bits;

    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign funct7_b5  = instr[30];
    assign is_r       = (opcode == 7'b0110011);
    assign is_i       = (opcode == 7'b0010011);
    assign is_lw      = (opcode == 7'b0000011);
    assign is_sw      = (opcode == 7'b0100011);
    assign is_beq     = (opcode == 7'b1100011);
    assign illegal_op = !(is_r || is_i || is_lw || is_sw || is_beq);
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], illegal_op};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = S_ID;
`ifdef MCTRL_ILLEGAL_TRAP_EN
            S_ID:  state_d = illegal_op ? S_TRAP : S_EX;
            S_TRAP: state_d = S_TRAP;
`else
            S_ID:  state_d = S_EX;
`endif
            S_EX:  state_d = S_MEM;
            S_MEM: state_d = S_WB;
            S_WB:  state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Immediate ALU ops never subtract: bit 30 of an I-type is immediate data, except for SRAI.
    always_comb begin
        alu_dec = ALU_ADD;
        if (is_r || is_i) begin
            case (funct3)
                3'b000:  alu_dec = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_dec = ALU_SLL;
                3'b010:  alu_dec = ALU_SLT;
                3'b100:  alu_dec = ALU_XOR;
                3'b101:  alu_dec = funct7_b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_dec = ALU_OR;
                3'b111:  alu_dec = ALU_AND;
                default: alu_dec = ALU_ADD;
            endcase
        end else if (is_beq) begin
            alu_dec = ALU_SUB;
        end
    end

    // Outputs are gated by rst directly so they drop before the next clock edge.
    always_comb begin
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUCtrl  = ALU_ADD & {ALU_W{1'b0}};
        loadPC   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        illegal  = 1'b0;
`endif
        if (!rst) begin
            ALUSrc   = is_i || is_lw || is_sw;
            MemToReg = is_lw;
            ALUCtrl  = alu_dec;
            case (state_q)
                S_MEM: begin
                    MemRead  = is_lw;
                    MemWrite = is_sw;
                end
                S_WB: begin
                    RegWrite = is_r || is_i || is_lw;
                    loadPC   = 1'b1;
                    PCSrc    = is_beq && Zero;
                end
`ifdef MCTRL_ILLEGAL_TRAP_EN
                S_TRAP: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign state_o = 3'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl; define MCTRL_ILLEGAL_TRAP_EN to exercise the TRAP path.
module tb_multicycle_ctrl;

    localparam int C_R   = 0;
    localparam int C_I   = 1;
    localparam int C_LW  = 2;
    localparam int C_SW  = 3;
    localparam int C_BEQ = 4;
    localparam int C_ILL = 5;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;
    localparam logic [3:0] A_SRL = 4'b1000;
    localparam logic [3:0] A_SLL = 4'b1001;
    localparam logic [3:0] A_SRA = 4'b1010;
    localparam logic [3:0] A_XOR = 4'b1101;

    typedef logic [14:0] vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state_o;
    logic        illegal_obs;
    vec_t        obs;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t exp_q[$];

    multicycle_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .Zero     (Zero),
        .PCSrc    (PCSrc),
        .ALUSrc   (ALUSrc),
        .RegWrite (RegWrite),
        .MemToReg (MemToReg),
        .ALUCtrl  (ALUCtrl),
        .loadPC   (loadPC),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .state_o  (state_o)
`ifdef MCTRL_ILLEGAL_TRAP_EN
        ,
        .illegal  (illegal_obs)
`endif
    );

`ifndef MCTRL_ILLEGAL_TRAP_EN
    assign illegal_obs = 1'b0;
`endif

    assign obs = {state_o, PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl,
                  loadPC, MemRead, MemWrite, illegal_obs};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t pack_vec(input logic [2:0] st, input logic pc, input logic as,
                                      input logic rw, input logic mtr, input logic [3:0] alu,
                                      input logic lp, input logic mr, input logic mw,
                                      input logic il);
        return {st, pc, as, rw, mtr, alu, lp, mr, mw, il};
    endfunction

    // Expected outputs for one phase of a legal or NOP instruction.
    function automatic vec_t expect_phase(input int cls, input logic [3:0] alu, input int p,
                                          input logic zero_wb);
        logic as, mtr, rw, lp, mr, mw, pc;
        as  = (cls == C_I) || (cls == C_LW) || (cls == C_SW);
        mtr = (cls == C_LW);
        mr  = (p == 3) && (cls == C_LW);
        mw  = (p == 3) && (cls == C_SW);
        rw  = (p == 4) && ((cls == C_R) || (cls == C_I) || (cls == C_LW));
        lp  = (p == 4);
        pc  = (p == 4) && (cls == C_BEQ) && zero_wb;
        return pack_vec(3'(p), pc, as, rw, mtr, alu, lp, mr, mw, 1'b0);
    endfunction

    task automatic checkOutput(input string tag, input vec_t got, input vec_t want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("[TB] FAIL %s: got %b expected %b (st,pc,as,rw,mtr,alu,lp,mr,mw,il)",
                      tag, got, want);
    endtask

    task automatic popAndCheck(input string tag);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL %s: got empty scoreboard expected an entry", tag);
        end else begin
            checkOutput(tag, obs, exp_q.pop_front());
        end
    endtask

    // Drives one instruction for 'phases' cycles starting at posedge+1 of its IF cycle.
    task automatic applyStimulus(input string name, input logic [31:0] ins, input int cls,
                                 input logic [3:0] alu, input logic zero_ex,
                                 input logic zero_wb, input int phases);
        for (int p = 0; p < phases; p++) begin
            instr = ins;
            Zero  = (p == 4) ? zero_wb : ((p == 2) ? zero_ex : 1'b0);
            exp_q.push_back(expect_phase(cls, alu, p, zero_wb));
            @(negedge clk);
            popAndCheck($sformatf("%s_p%0d", name, p));
            if (p < phases - 1 || phases == 5) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h0080A203;
        Zero  = 1'b1;
        #12;
        exp_q.push_back('0);
        popAndCheck("reset_hold");
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        popAndCheck("reset_after_edge");
        rst = 1'b0;

        applyStimulus("add",  32'h002081B3, C_R,   A_ADD, 1'b0, 1'b1, 5);
        applyStimulus("sub",  32'h402081B3, C_R,   A_SUB, 1'b0, 1'b0, 5);
        applyStimulus("srai", 32'h4012D293, C_I,   A_SRA, 1'b0, 1'b0, 5);
        applyStimulus("addi_b30", 32'hC0000093, C_I, A_ADD, 1'b0, 1'b0, 5);
        applyStimulus("slt",  32'h0020A1B3, C_R,   A_SLT, 1'b0, 1'b0, 5);
        applyStimulus("sll",  32'h002091B3, C_R,   A_SLL, 1'b0, 1'b0, 5);
        applyStimulus("srl",  32'h0020D1B3, C_R,   A_SRL, 1'b0, 1'b0, 5);
        applyStimulus("xor",  32'h0020C1B3, C_R,   A_XOR, 1'b0, 1'b0, 5);
        applyStimulus("or",   32'h0020E1B3, C_R,   A_OR,  1'b0, 1'b0, 5);
        applyStimulus("and",  32'h0020F1B3, C_R,   A_AND, 1'b0, 1'b0, 5);
        applyStimulus("lw",   32'h0080A203, C_LW,  A_ADD, 1'b0, 1'b0, 5);
        applyStimulus("sw",   32'h0020A223, C_SW,  A_ADD, 1'b0, 1'b0, 5);
        applyStimulus("beq_taken",  32'h00208463, C_BEQ, A_SUB, 1'b0, 1'b1, 5);
        applyStimulus("beq_ex_only", 32'h00208463, C_BEQ, A_SUB, 1'b1, 1'b0, 5);

        // Abort a store in MEM with an asynchronous reset mid-cycle.
        applyStimulus("sw_abort", 32'h0020A223, C_SW, A_ADD, 1'b0, 1'b0, 4);
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back('0);
        popAndCheck("abort_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("add_after_abort", 32'h002081B3, C_R, A_ADD, 1'b0, 1'b0, 5);

`ifdef MCTRL_ILLEGAL_TRAP_EN
        applyStimulus("ill", 32'h0000007F, C_ILL, A_ADD, 1'b0, 1'b0, 2);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(pack_vec(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD, 1'b0, 1'b0, 1'b0, 1'b1));
            @(negedge clk);
            popAndCheck($sformatf("trap_%0d", i));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        exp_q.push_back('0);
        popAndCheck("trap_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("add_after_trap", 32'h002081B3, C_R, A_ADD, 1'b0, 1'b0, 5);
`else
        applyStimulus("ill_nop", 32'h0000007F, C_ILL, A_ADD, 1'b0, 1'b1, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control unit that sits directly upstream of the RV32 datapath and drives all of its control inputs.
- A 5-state FSM (IF, ID, EX, MEM, WB) sequences every instruction, decoding opcode/funct3/funct7 from the current instruction word.
- Uses the datapath's Zero flag to resolve BEQ.
- Produces exactly one loadPC pulse per instruction.

Parameters:
- NUM_STATES, 5, number of FSM states; fixed, and the state register is 3 bits wide.
- ALU_W, 4, width of ALUCtrl.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  32  current instruction word; held stable by the instruction memory from ID through WB.
- Zero  input  1  ALU zero flag from the datapath.
- PCSrc  output  1  1 selects the branch target, 0 selects PC+4.
- ALUSrc  output  1  1 selects the immediate as ALU operand 2.
- RegWrite  output  1  register-file write enable.
- MemToReg  output  1  1 selects memory read data for writeback.
- ALUCtrl  output  4  ALU operation code.
- loadPC  output  1  PC update strobe.
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- state_o  output  3  current FSM state, for debug and verification.

Behaviour:
- Reset: rst asserted asynchronously forces state=IF. While rst is high, all outputs are 0 and ALUCtrl=4'b0000.
  - Reset mid-instruction aborts the instruction; no loadPC, RegWrite or MemWrite pulse is produced afterwards.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4.
- Transitions: IF->ID->EX->MEM->WB->IF, unconditionally, one state per clock.
  - Every instruction takes 5 cycles, including those with no memory phase.
  - 5..7 are unreachable; if entered, the next state is IF.
- Opcode classes: R=0110011, IALU=0010011, LW=0000011, SW=0100011, BEQ=1100011. Any other opcode is illegal.
- ALUCtrl decode is combinational from instr and is valid in every state except reset:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
  - R / IALU: funct3 000 gives ADD, except R with funct7[5]=1 gives SUB. funct3 001 SLL, 010 SLT, 100 XOR, 101 SRL (SRA when funct7[5]=1), 110 OR, 111 AND.
  - IALU never produces SUB.
  - LW / SW give ADD. BEQ gives SUB. Illegal opcode gives ADD.
- ALUSrc is 1 for IALU, LW and SW; 0 otherwise. It is combinational from instr.
- MemToReg is 1 for LW only. It is combinational from instr.
- MemRead is 1 only in MEM and only for LW.
- MemWrite is 1 only in MEM and only for SW.
- RegWrite is 1 only in WB, for R, IALU and LW.
  - Never for SW, BEQ or illegal opcodes.
  - Writes to x0 are not filtered here; the register file handles them.
- loadPC is 1 only in WB, for every instruction class. It is a single-cycle pulse.
- PCSrc is 1 only in WB when opcode=BEQ and Zero=1 in that same cycle.
  - Zero is sampled combinationally; no latching.
- Latency: after rst deasserts, the first loadPC is seen in the 5th rising-edge cycle, i.e. with the FSM in WB. Thereafter loadPC repeats every 5 cycles.
- Illegal opcode (without the optional feature): the instruction is treated as a NOP — no RegWrite, MemRead or MemWrite; loadPC fires in WB with PCSrc=0.

Optional Feature:
- Macro: MCTRL_ILLEGAL_TRAP_EN.
- When defined:
  - Adds a sixth state TRAP=5 and an output port illegal (1 bit).
  - An illegal opcode detected in ID moves the FSM to TRAP instead of EX.
  - TRAP is sticky: all enables are 0, loadPC=0, illegal=1. Only rst exits it.
  - illegal resets to 0.
- When not defined: no TRAP state and no illegal port; illegal opcodes behave as NOPs, as described in Behaviour.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3): state steps 0,1,2,3,4. In WB, RegWrite=1, loadPC=1, PCSrc=0, ALUCtrl=0010, ALUSrc=0. MemRead=MemWrite=0 throughout.
- SUB x3,x1,x2 (0x402081B3), then SRAI x5,x5,1 (0x4012D293): ALUCtrl=0110 for SUB. ALUCtrl=1010 with ALUSrc=1 for SRAI.
- LW x4,8(x1) (0x0080A203): MemRead=1 only in MEM. In WB, RegWrite=1, MemToReg=1, loadPC=1. ALUCtrl=0010.
- SW x2,4(x1) (0x0020A223): MemWrite=1 only in MEM. RegWrite never 1. loadPC=1 in WB.
- BEQ (0x00208463), run twice: with Zero=1 in WB, PCSrc=1 and loadPC=1; with Zero=0 in WB, PCSrc=0 and loadPC=1. Zero toggled in EX has no effect on PCSrc.
- Assert rst while in MEM of SW: MemWrite drops to 0 immediately, before the next clock, and the state returns to IF. Run with MCTRL_ILLEGAL_TRAP_EN and opcode 0x7F: the FSM goes to TRAP after ID with illegal=1, loadPC stays 0 for 20 cycles, and rst clears both.
